// File: rtl/ddc_hb_pkg.sv
// Shared coefficients, widths and round/saturate helper for the
// half-band decimate-by-2 FIR.
package ddc_hb_pkg;

   localparam int COEF_WIDTH = 16;
   localparam int SHIFT      = 15;

   localparam logic signed [COEF_WIDTH-1:0] C0 = 16'sd16384;
   localparam logic signed [COEF_WIDTH-1:0] C1 = 16'sd10154;
   localparam logic signed [COEF_WIDTH-1:0] C3 = -16'sd2349;
   localparam logic signed [COEF_WIDTH-1:0] C5 = 16'sd387;

   function automatic int acc_width(input int width);
      return width + 19;
   endfunction

   // Round half up, drop SHIFT fraction bits, clip to a width-bit signed range.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int width);
      logic signed [63:0] rnd_s;
      logic signed [63:0] hi_s;
      logic signed [63:0] lo_s;
      logic signed [63:0] res_s;
      rnd_s = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
      hi_s  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo_s  = -(64'sd1 <<< (width - 1));
      if (rnd_s > hi_s) begin
         res_s = hi_s;
      end else if (rnd_s < lo_s) begin
         res_s = lo_s;
      end else begin
         res_s = rnd_s;
      end
      return res_s;
   endfunction

endpackage

// File: rtl/ddc_hb_decim_fir_rail.sv
// One I or Q rail: 11-deep delay line, symmetric pre-adders, pipelined MAC
// and round/saturate into a held output register.
module ddc_hb_fir_rail
   import ddc_hb_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit INPUT_PAIR = 1'b0
)
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_delay_data,
   input  logic             i_prod_en,
   input  logic             i_sum_en,
   input  logic             i_out_en,
   output logic [WIDTH-1:0] o_data
);

   localparam int ACC_W = acc_width(WIDTH);
   localparam int TAPS  = 11;

   logic signed [WIDTH-1:0] tap_r [TAPS];
   logic signed [WIDTH:0]   pre5_s, pre3_s, pre1_s;
   logic signed [ACC_W-1:0] mul5_s, mul3_s, mul1_s, mul0_s;
   logic signed [ACC_W-1:0] prod5_r, prod3_r, prod1_r, prod0_r;
   logic signed [ACC_W-1:0] sum_r;
   logic signed [WIDTH-1:0] data_r;

   // Delay line: tap_r[k] holds x[n-k]; pair mode shifts two samples at once.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < TAPS; k++) tap_r[k] <= {WIDTH{1'b0}};
      end else if (i_shift) begin
         if (INPUT_PAIR) begin
            tap_r[0] <= i_data;
            tap_r[1] <= i_delay_data;
            for (int k = 2; k < TAPS; k++) tap_r[k] <= tap_r[k-2];
         end else begin
            tap_r[0] <= i_data;
            for (int k = 1; k < TAPS; k++) tap_r[k] <= tap_r[k-1];
         end
      end
   end

   // Symmetric pre-adds and full-precision products (odd taps other than centre are zero).
   always_comb begin
      pre5_s = {tap_r[0][WIDTH-1], tap_r[0]} + {tap_r[10][WIDTH-1], tap_r[10]};
      pre3_s = {tap_r[2][WIDTH-1], tap_r[2]} + {tap_r[8][WIDTH-1], tap_r[8]};
      pre1_s = {tap_r[4][WIDTH-1], tap_r[4]} + {tap_r[6][WIDTH-1], tap_r[6]};
      mul5_s = ACC_W'(pre5_s) * ACC_W'(C5);
      mul3_s = ACC_W'(pre3_s) * ACC_W'(C3);
      mul1_s = ACC_W'(pre1_s) * ACC_W'(C1);
      mul0_s = ACC_W'(tap_r[5]) * ACC_W'(C0);
   end

   // Product register, accumulator register, and rounded output register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         prod5_r <= {ACC_W{1'b0}};
         prod3_r <= {ACC_W{1'b0}};
         prod1_r <= {ACC_W{1'b0}};
         prod0_r <= {ACC_W{1'b0}};
         sum_r   <= {ACC_W{1'b0}};
         data_r  <= {WIDTH{1'b0}};
      end else begin
         if (i_prod_en) begin
            prod5_r <= mul5_s;
            prod3_r <= mul3_s;
            prod1_r <= mul1_s;
            prod0_r <= mul0_s;
         end
         if (i_sum_en) begin
            sum_r <= prod5_r + prod3_r + prod1_r + prod0_r;
         end
         if (i_out_en) begin
            data_r <= WIDTH'(round_sat(64'(sum_r), WIDTH));
         end
      end
   end

   assign o_data = data_r;

endmodule

// File: rtl/ddc_hb_decim_fir.sv
// Complex half-band decimate-by-2 FIR: phase tracking and valid pipeline
// shared by two identical filter rails.
module ddc_hb_decim_fir
   import ddc_hb_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit INPUT_PAIR = 1'b0
)
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_inph_data,
   input  logic [WIDTH-1:0] i_quad_data,
   input  logic [WIDTH-1:0] i_inph_delay_data,
   input  logic [WIDTH-1:0] i_quad_delay_data,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_inph_data,
   output logic [WIDTH-1:0] o_quad_data,
   output logic             o_valid
);

   logic       run_r;
   logic       phase_r;
   logic [2:0] vld_r;
   logic       o_valid_r;
   logic       accept_s;
   logic       trig_s;

   // A valid is accepted only once the first edge after reset release has passed.
   always_comb begin
      accept_s = i_valid & run_r;
      if (INPUT_PAIR) begin
         trig_s = accept_s;
      end else begin
         trig_s = accept_s & phase_r;
      end
   end

   // Phase bit and three-stage valid pipeline feeding the output strobe.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         run_r     <= 1'b0;
         phase_r   <= 1'b0;
         vld_r     <= 3'b000;
         o_valid_r <= 1'b0;
      end else begin
         run_r     <= 1'b1;
         vld_r     <= {vld_r[1:0], trig_s};
         o_valid_r <= vld_r[2];
         if (accept_s) begin
            phase_r <= ~phase_r;
         end
      end
   end

   assign o_valid = o_valid_r;

   ddc_hb_fir_rail #(.WIDTH(WIDTH), .INPUT_PAIR(INPUT_PAIR)) u_inph (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_shift      (accept_s),
      .i_data       (i_inph_data),
      .i_delay_data (i_inph_delay_data),
      .i_prod_en    (vld_r[0]),
      .i_sum_en     (vld_r[1]),
      .i_out_en     (vld_r[2]),
      .o_data       (o_inph_data)
   );

   ddc_hb_fir_rail #(.WIDTH(WIDTH), .INPUT_PAIR(INPUT_PAIR)) u_quad (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_shift      (accept_s),
      .i_data       (i_quad_data),
      .i_delay_data (i_quad_delay_data),
      .i_prod_en    (vld_r[0]),
      .i_sum_en     (vld_r[1]),
      .i_out_en     (vld_r[2]),
      .o_data       (o_quad_data)
   );

endmodule

// File: tb/tb_ddc_hb_decim_fir.sv
// Bench for ddc_hb_decim_fir: a single-sample instance and a pair-mode
// instance run side by side against a sample-history reference model.
module tb_ddc_hb_decim_fir;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] s_i, s_q, s_di, s_dq, s_oi, s_oq;
   logic [W-1:0] p_i, p_q, p_di, p_dq, p_oi, p_oq;
   logic         s_v, p_v, s_ov, p_ov;

   always #5 clk = ~clk;

   ddc_hb_decim_fir #(.WIDTH(W), .INPUT_PAIR(1'b0)) u_single (
      .i_clock(clk), .i_reset(rst_n),
      .i_inph_data(s_i), .i_quad_data(s_q),
      .i_inph_delay_data(s_di), .i_quad_delay_data(s_dq),
      .i_valid(s_v),
      .o_inph_data(s_oi), .o_quad_data(s_oq), .o_valid(s_ov)
   );

   ddc_hb_decim_fir #(.WIDTH(W), .INPUT_PAIR(1'b1)) u_pair (
      .i_clock(clk), .i_reset(rst_n),
      .i_inph_data(p_i), .i_quad_data(p_q),
      .i_inph_delay_data(p_di), .i_quad_delay_data(p_dq),
      .i_valid(p_v),
      .o_inph_data(p_oi), .o_quad_data(p_oq), .o_valid(p_ov)
   );

   typedef struct { int due; int yi; int yq; } exp_t;
   exp_t eq0[$];
   exp_t eq1[$];
   int   cap0[$];
   int   cap1[$];
   int   hist [2][2][0:4095];
   int   nsamp [2];
   int   last_i [2];
   int   last_q [2];
   int   coef [11] = '{387, 0, -2349, 0, 10154, 16384, 10154, 0, -2349, 0, 387};
   int   imp_exp [7] = '{12, -72, 310, 310, -72, 12, 0};
   int   cyc, n_tests, n_fail, n_out0, n_val0;
   bit   run_m;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int rnd_s();
      logic signed [W-1:0] v;
      v = W'($urandom);
      return int'(v);
   endfunction

   // y[n] straight from the tap equation, zero history before x[0]
   function automatic int ref_y(input int d, input int r, input int n);
      longint acc;
      acc = 0;
      for (int k = 0; k < 11; k++)
         if (n - k >= 0) acc += longint'(coef[k]) * longint'(hist[d][r][n-k]);
      acc = (acc + 64'sd16384) >>> 15;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic add_sample(input int d, input int xi, input int xq);
      if (nsamp[d] > 4095) begin
         $display("FAIL history_overflow observed=%0d expected<=4095", nsamp[d]);
         $fatal(1, "history overflow");
      end
      hist[d][0][nsamp[d]] = xi;
      hist[d][1][nsamp[d]] = xq;
      nsamp[d]++;
   endtask

   task automatic push_exp(input int d);
      exp_t e;
      e.due = cyc + 3;
      e.yi  = ref_y(d, 0, nsamp[d] - 1);
      e.yq  = ref_y(d, 1, nsamp[d] - 1);
      if (d == 0) eq0.push_back(e);
      else eq1.push_back(e);
   endtask

   task automatic model_edge();
      if (rst_n !== 1'b1) begin
         run_m = 1'b0;
      end else if (!run_m) begin
         run_m = 1'b1;
      end else begin
         if (s_v) begin
            n_val0++;
            add_sample(0, int'($signed(s_i)), int'($signed(s_q)));
            if (nsamp[0] % 2 == 0) push_exp(0);
         end
         if (p_v) begin
            add_sample(1, int'($signed(p_di)), int'($signed(p_dq)));
            add_sample(1, int'($signed(p_i)), int'($signed(p_q)));
            push_exp(1);
         end
      end
   endtask

   task automatic check_outputs();
      if (s_ov === 1'b1) begin
         cap0.push_back(int'($signed(s_oi)));
         n_out0++;
      end
      if (p_ov === 1'b1) cap1.push_back(int'($signed(p_oi)));
      if (eq0.size() > 0 && eq0[0].due == cyc) begin
         chk("s_valid", s_ov, 1);
         last_i[0] = eq0[0].yi;
         last_q[0] = eq0[0].yq;
         void'(eq0.pop_front());
      end else begin
         chk("s_valid", s_ov, 0);
      end
      chk("s_inph", $signed(s_oi), last_i[0]);
      chk("s_quad", $signed(s_oq), last_q[0]);
      if (eq1.size() > 0 && eq1[0].due == cyc) begin
         chk("p_valid", p_ov, 1);
         last_i[1] = eq1[0].yi;
         last_q[1] = eq1[0].yq;
         void'(eq1.pop_front());
      end else begin
         chk("p_valid", p_ov, 0);
      end
      chk("p_inph", $signed(p_oi), last_i[1]);
      chk("p_quad", $signed(p_oq), last_q[1]);
   endtask

   task automatic tick(input bit sv, input int si, input int sq, input bit pv,
                       input int pdi, input int pdq, input int pi, input int pq);
      s_v = sv;  s_i = W'(si);  s_q = W'(sq);
      s_di = W'($urandom); s_dq = W'($urandom);
      p_v = pv;  p_i = W'(pi);  p_q = W'(pq);  p_di = W'(pdi);  p_dq = W'(pdq);
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      eq0.delete(); eq1.delete(); cap0.delete(); cap1.delete();
      nsamp = '{0, 0}; last_i = '{0, 0}; last_q = '{0, 0};
      n_out0 = 0; n_val0 = 0; run_m = 1'b0;
      idle(cycles);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic drain_check(input string tag);
      idle(6);
      chk({tag, "_s_pending"}, eq0.size(), 0);
      chk({tag, "_p_pending"}, eq1.size(), 0);
   endtask

   task automatic run_impulse(input string tag);
      cap0.delete(); cap1.delete();
      for (int n = 0; n < 16; n++) begin
         if (n < 8) tick(1'b1, (n == 1) ? 1000 : 0, 0, 1'b1, 0, 0, (n == 0) ? 1000 : 0, 0);
         else tick(1'b1, 0, 0, 1'b0, 0, 0, 0, 0);
      end
      drain_check(tag);
      chk({tag, "_s_count"}, cap0.size(), 8);
      chk({tag, "_p_count"}, cap1.size(), 8);
      for (int k = 0; k < 7; k++) begin
         chk({tag, "_s_seq"}, (k < cap0.size()) ? cap0[k] : -99999, imp_exp[k]);
         chk({tag, "_p_seq"}, (k < cap1.size()) ? cap1[k] : -99999, imp_exp[k]);
      end
   endtask

   task automatic run_const(input string tag, input int ci, input int cq);
      for (int n = 0; n < 24; n++)
         tick(1'b1, ci, cq, n < 12, ci, cq, ci, cq);
      drain_check(tag);
      chk({tag, "_s_i"}, $signed(s_oi), ci);
      chk({tag, "_s_q"}, $signed(s_oq), cq);
      chk({tag, "_p_i"}, $signed(p_oi), ci);
      chk({tag, "_p_q"}, $signed(p_oq), cq);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      s_v = 1'b0; p_v = 1'b0;
      s_i = '0; s_q = '0; s_di = '0; s_dq = '0;
      p_i = '0; p_q = '0; p_di = '0; p_dq = '0;
      rst_n = 1'b1;
      #1;
      do_reset(3);
      chk("reset_s_valid", s_ov, 0);
      chk("reset_p_inph", $signed(p_oi), 0);

      run_impulse("impulse");

      do_reset(2);
      run_const("dc", 1000, -500);
      do_reset(2);
      run_const("fullscale", 32767, 32767);

      // steps from full negative to full positive at x[13]
      do_reset(2);
      cap0.delete(); cap1.delete();
      for (int n = 0; n < 24; n++) begin
         int a, b;
         a = (2 * n <= 12) ? -32768 : 32767;
         b = (2 * n + 1 <= 12) ? -32768 : 32767;
         tick(1'b1, (n <= 12) ? -32768 : 32767, 0, n < 12, a, 0, b, 0);
      end
      drain_check("sat");
      chk("sat_s_n19", (cap0.size() > 9) ? cap0[9] : -99999, 32767);
      chk("sat_p_n19", (cap1.size() > 9) ? cap1[9] : -99999, 32767);

      do_reset(2);
      for (int n = 0; n < 400; n++)
         tick(1'($urandom_range(0, 1)), rnd_s(), rnd_s(),
              1'($urandom_range(0, 1)), rnd_s(), rnd_s(), rnd_s(), rnd_s());
      drain_check("gapped");
      chk("gapped_count", n_out0, n_val0 / 2);

      // reset while the x[1] result is in flight, then repeat the impulse
      do_reset(2);
      tick(1'b1, 0, 0, 1'b1, 0, 0, 1000, 0);
      tick(1'b1, 1000, 0, 1'b0, 0, 0, 0, 0);
      do_reset(2);
      chk("midreset_s_out", $signed(s_oi), 0);
      chk("midreset_p_out", $signed(p_oi), 0);
      chk("midreset_count", n_out0, 0);
      run_impulse("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ddc_hb_decim_fir.md
# ddc_hb_decim_fir

Complex (I/Q) half-band decimate-by-2 FIR for the digital down-converter. One parameterized block implements every stage of the decimation cascade: the first stage takes two samples per valid (INPUT_PAIR=1), and later stages take one sample per valid (INPUT_PAIR=0). Each stage halves the sample rate with unity DC gain and a fixed 11-tap half-band response.

## Interface
- WIDTH, 16, sample width of every I/Q data port, two's complement
- INPUT_PAIR, 0, 0: one sample per i_valid, output on every second valid; 1: sample pair per i_valid, output on every valid
- i_clock  in  1  sole clock, rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_inph_data  in  WIDTH  newest in-phase sample
- i_quad_data  in  WIDTH  newest quadrature sample
- i_inph_delay_data  in  WIDTH  older in-phase sample of the pair; ignored when INPUT_PAIR=0
- i_quad_delay_data  in  WIDTH  older quadrature sample of the pair; ignored when INPUT_PAIR=0
- i_valid  in  1  inputs valid this cycle; no backpressure
- o_inph_data  out  WIDTH  filtered, decimated in-phase output
- o_quad_data  out  WIDTH  filtered, decimated quadrature output
- o_valid  out  1  single-cycle output strobe

## Operation
- Number the input samples x[0], x[1], … from reset. With INPUT_PAIR=1, each valid delivers x[2m] on the delay ports and x[2m+1] on the data ports.
- Outputs are produced only at odd n (the newest sample is x[2m+1]):
  y = (C5·(x[n]+x[n-10]) + C3·(x[n-2]+x[n-8]) + C1·(x[n-4]+x[n-6]) + C0·x[n-5] + 2^14) >>> 15
- Coefficients: C0=16384, C1=10154, C3=-2349, C5=387. These are signed 16-bit values in Q1.15. All other taps are 0. Taps sum to 32768, so DC gain is exactly 1.
- Arithmetic:
  - Pre-add symmetric pairs in WIDTH+1 bits.
  - Multiply and accumulate at full precision in WIDTH+19 bits.
  - Round half up by adding 2^14, then arithmetic shift right by 15.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Never wrap.
- I and Q rails are identical and independent, and share the control logic.
- The delay line holds the 11 most recent samples per rail.
  - When n<10, missing history is 0.
- INPUT_PAIR=0: a phase bit toggles on each accepted valid. The valid carrying an odd-index sample triggers an output.
- INPUT_PAIR=1: every valid shifts in two samples and triggers an output.
- Cycles with i_valid=0 change no state except pipeline advance. Any valid pattern is legal, including every cycle.

## Timing
- Latency is fixed at 3 cycles. o_valid pulses high for exactly one cycle, 3 rising edges after the edge that samples the triggering i_valid.
- Throughput is one output per 2 valids (INPUT_PAIR=0) or one per valid (INPUT_PAIR=1). A fully pipelined design accepts i_valid every cycle.
- o_inph_data and o_quad_data update only with o_valid and hold between strobes.
- Reset state:
  - All outputs are 0, including o_valid.
  - The delay line is cleared.
  - The phase bit is 0, so the next sample is x[0].
  - The pipeline is flushed.
- Reset asserted mid-operation: an in-flight result is discarded and no o_valid is emitted. The first output after release is computed against zero history.
- i_valid in the same cycle as reset release is ignored.

## Structure
- Package ddc_hb_pkg holds:
  - coefficient localparams C0, C1, C3, C5 and COEF_WIDTH=16
  - the shift constant 15
  - accumulator width (WIDTH+19) as a function
  - a saturate/round function
- Sub-module ddc_hb_fir_rail: per-rail delay line, pre-adders, MAC, and round/saturate. It is instantiated twice (I, Q).
- The top holds the phase bit and the valid pipeline.

## Test plan
- Impulse, INPUT_PAIR=0: I input x[1]=1000, all others 0, Q=0. Successive I outputs are 12, -72, 310, 310, -72, 12, 0. Q stays 0. Each o_valid arrives 3 cycles after the odd-index valid.
- DC, both modes: constant I=1000, Q=-500. After 11 samples, outputs are exactly 1000 and -500. Constant +32767 gives 32767 with no overflow.
- Saturation: x[0..12]=-32768, then +32767 from x[13]. Output at n=19 clips to +32767. No output wraps sign.
- Pair mode: feed the impulse of test 1 as pairs (delay=x[2m], data=x[2m+1]). This gives the same output sequence, with o_valid on every valid.
- Gapped valid: random i_valid duty (including back-to-back). Outputs match a bit-exact reference model, and the count equals floor(valids/2).
- Reset mid-stream: assert i_reset for 2 cycles while an output is in the pipeline. No o_valid, and outputs read 0. After release, the impulse test reproduces exactly.
